serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder: one full-adder bit slice plus a carry flip-flop, iterated LSB-first over WIDTH clock cycles.
- Sits directly upstream of the word-level consumers. It replaces a WIDTH-wide ripple of full adders where area matters more than latency.
- Operands are accepted on a valid/ready handshake. The sum and carry-out are presented on a valid/ready handshake.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit_cell.sv | 13 +
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full-adder slice: sum and majority carry.
module fa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port selecting a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   b_load;
  logic               c_load;
  logic               fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and inject a carry of one.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  fa_bit_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    s_d         = s_q;
    co_d        = co_q;
    carry_d     = carry_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = c_load;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        carry_d = fa_co;
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          // Park the counter so it never reaches WIDTH.
          count_d     = '0;
          co_d        = fa_co;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_q         <= '0;
      co_q        <= 1'b0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      s_q         <= s_d;
      co_q        <= co_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       co;
  logic       busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[7];

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Ticks until out_valid is seen, bounded; returns edges taken.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic eco);
    int n;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({name, " busy"}, 32'(busy), 32'd1);
    chk({name, " in_ready_run"}, 32'(in_ready), 32'd0);
    wait_out(n);
    chk({name, " latency"}, 32'(n), 32'd8);
    chk({name, " s"}, 32'(s), 32'(es));
    chk({name, " co"}, 32'(co), 32'(eco));
    tick();
    chk({name, " out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, " in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, s: 8'h00, co: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[4] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, co: 1'b0};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, s: 8'hFF, co: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #3;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst s", 32'(s), 32'd0);
    chk("rst co", 32'(co), 32'd0);
    #9;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
    end

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp latency", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp s", 32'(s), 32'h03);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp transfer", 32'(out_valid), 32'd0);
    chk("bp in_ready", 32'(in_ready), 32'd1);
    chk("bp s_hold", 32'(s), 32'h03);

    // Busy rejection, then simultaneous out transfer with pending in_valid.
    a = 8'h20; b = 8'h03; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    chk("rej in_ready", 32'(in_ready), 32'd0);
    wait_out(n);
    chk("rej latency", 32'(n), 32'd6);
    chk("rej s", 32'(s), 32'h23);
    tick();
    chk("simul out_valid", 32'(out_valid), 32'd0);
    chk("simul not_accepted", 32'(in_ready), 32'd1);
    chk("simul busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("held accept busy", 32'(busy), 32'd1);
    wait_out(n);
    chk("held latency", 32'(n), 32'd8);
    chk("held s", 32'(s), 32'h02);
    chk("held co", 32'(co), 32'd0);
    tick();

    // Reset mid-RUN.
    a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst s", 32'(s), 32'd0);
    chk("mid rst co", 32'(co), 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mid rst no_valid", 32'(n), 32'd0);
    run_op("post rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub 10-01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("sub 01-02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
